// File: rtl/pipe_drain_buf_pkg.sv
// Shared constants and helpers for the pipe_drain_buf slice.
// COEF_W is the width of one Kyber coefficient and is the default data width.
// ptr_w() gives the index width for a storage array of a given depth and
// never returns less than one bit.
package pipe_drain_buf_pkg;

  localparam int unsigned COEF_W    = 12;
  localparam int unsigned MAX_DEPTH = 64;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_drain_buf_if.sv
// Handshake bundle between the upstream pipeline, the drain buffer and the
// downstream consumer.
//   in_issue  : upstream launches one item into the pipeline this cycle
//   can_issue : launching is permitted this cycle
//   pipe_vld  : pipeline output valid
//   pipe_dat  : pipeline output data
//   out_vld   : buffered item available
//   out_dat   : head-of-queue data
//   out_rdy   : consumer accepts the head item
//   occ       : stored entry count
//   ovf       : sticky overflow flag
// The master modport is the environment (pipeline plus consumer).
// The slave modport is the buffer.
interface pipe_drain_buf_if
  import pipe_drain_buf_pkg::*;
#(
  parameter int unsigned W     = COEF_W,
  parameter int unsigned DEPTH = 8
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          in_issue;
  logic          can_issue;
  logic          pipe_vld;
  logic [W-1:0]  pipe_dat;
  logic          out_vld;
  logic [W-1:0]  out_dat;
  logic          out_rdy;
  logic [CW-1:0] occ;
  logic          ovf;

  modport master (
    output in_issue, pipe_vld, pipe_dat, out_rdy,
    input  can_issue, out_vld, out_dat, occ, ovf
  );

  modport slave (
    input  in_issue, pipe_vld, pipe_dat, out_rdy,
    output can_issue, out_vld, out_dat, occ, ovf
  );

endinterface

// File: rtl/pipe_drain_mem.sv
// DEPTH x W storage for the drain buffer.
// The block has one write port at the tail pointer and an asynchronous read
// of the head pointer. Both pointers are registered and wrap from DEPTH-1 to
// 0, so DEPTH does not have to be a power of two. The array itself is not
// reset.
//   clk    : clock, rising edge
//   rst    : synchronous active-low reset; clears both pointers
//   wr_en  : write wr_dat at the tail and advance the tail
//   wr_dat : write data
//   rd_en  : advance the head
//   rd_dat : entry at the head, combinational
module pipe_drain_mem
  import pipe_drain_buf_pkg::*;
#(
  parameter int unsigned W     = COEF_W,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat
);

  localparam int unsigned   PW   = ptr_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= bump(wr_ptr);
      if (rd_en) rd_ptr <= bump(rd_ptr);
    end
  end

  assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/pipe_drain_buf.sv
// Credit-based drain buffer behind a fixed-latency, non-stallable pipeline.
// A reservation counter counts stored plus in-flight items. Launches are
// only permitted while that count is below DEPTH, so every permitted item
// has a slot when it leaves the pipeline. The queue is first-word-fall-
// through and has no bypass. out_dat reads zero while the queue is empty.
//   clk : clock, rising edge
//   rst : synchronous active-low reset
//   bus : pipe_drain_buf_if slave modport
//         (in_issue/can_issue, pipe_vld/pipe_dat, out_vld/out_dat/out_rdy,
//          occ, ovf)
// K documents the upstream latency. The credit scheme does not need its
// value.
module pipe_drain_buf
  import pipe_drain_buf_pkg::*;
#(
  parameter int unsigned W     = COEF_W,
  parameter int unsigned K     = 3,
  parameter int unsigned DEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  pipe_drain_buf_if.slave  bus
);

  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("pipe_drain_buf: DEPTH must be in 1..64");
  end
  if (K < 1) begin : g_bad_k
    $error("pipe_drain_buf: K must be at least 1");
  end

  logic [CW-1:0] res;
  logic [CW-1:0] occ_q;
  logic          ovf_q;
  logic          launch;
  logic          pop;
  logic          full;
  logic          push;
  logic          vld;
  logic [W-1:0]  head;

  always_comb begin
    vld    = (occ_q != '0);
    full   = (occ_q == FULL);
    launch = bus.in_issue && (res < FULL);
    pop    = vld && bus.out_rdy;
    // A pop in the same cycle frees the slot, so a push at full is allowed.
    push   = bus.pipe_vld && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      res   <= '0;
      occ_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      // Do not decrement below zero. Items that were launched before a reset
      // can still arrive and be popped after the counter has been cleared.
      if (launch && !pop)
        res <= res + 1'b1;
      else if (!launch && pop && res != '0)
        res <= res - 1'b1;

      if (push && !pop)
        occ_q <= occ_q + 1'b1;
      else if (pop && !push)
        occ_q <= occ_q - 1'b1;

      if (bus.pipe_vld && full && !pop)
        ovf_q <= 1'b1;
    end
  end

  pipe_drain_mem #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push),
    .wr_dat (bus.pipe_dat),
    .rd_en  (pop),
    .rd_dat (head)
  );

  assign bus.can_issue = (res < FULL);
  assign bus.out_vld   = vld;
  assign bus.out_dat   = vld ? head : '0;
  assign bus.occ       = occ_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_drain_buf.sv
module tb_pipe_drain_buf;

  localparam int unsigned W     = 12;
  localparam int unsigned K     = 3;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_drain_buf_if #(.W(W), .DEPTH(DEPTH)) bus ();

  pipe_drain_buf #(.W(W), .K(K), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int nd     = 0;
  bit rnd    = 1'b0;

  logic [W-1:0] l_dat   = '0;
  logic         inj_vld = 1'b0;
  logic [W-1:0] inj_dat = '0;

  // Pipeline model: accepted launches delayed by K cycles.
  logic         sv [K] = '{default: 1'b0};
  logic [W-1:0] sd [K] = '{default: '0};
  logic [W-1:0] q [$];

  assign bus.pipe_vld = sv[K-1] | inj_vld;
  assign bus.pipe_dat = inj_vld ? inj_dat : sd[K-1];

  always @(posedge clk) begin
    sv[0] <= bus.in_issue && bus.can_issue;
    sd[0] <= l_dat;
    for (int i = 1; i < K; i++) begin
      sv[i] <= sv[i-1];
      sd[i] <= sd[i-1];
    end
    if (bus.in_issue && bus.can_issue) q.push_back(l_dat);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard and per-cycle model checks, away from the active edge.
  always @(negedge clk) begin
    int nv;
    if (!rst) begin
      // Reset drops stored items. Items still in the pipeline arrive later.
      q.delete();
      for (int i = K - 2; i >= 0; i--)
        if (sv[i]) q.push_back(sd[i]);
    end else begin
      if (rnd) begin
        nv = 0;
        for (int i = 0; i < K; i++) if (sv[i]) nv++;
        chk("rnd_can_issue", 32'(bus.can_issue), 32'(q.size() < DEPTH));
        chk("rnd_occ", 32'(bus.occ), 32'(q.size() - nv));
        chk("rnd_ovf", 32'(bus.ovf), 32'd0);
      end
      if (bus.out_vld && bus.out_rdy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got %0h expected none at %0t", bus.out_dat, $time);
        end else begin
          chk("sb_data", 32'(bus.out_dat), 32'(q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    logic acc;
    acc = bus.in_issue && bus.can_issue;
    @(posedge clk);
    #1;
    if (acc) nd++;
    l_dat = nd[W-1:0];
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_issue = 1'b0;
    bus.out_rdy  = 1'b0;
    inj_vld      = 1'b0;
    repeat (K + 2) tick();
    rst = 1'b1;
  endtask

  typedef struct {
    logic       ii;
    logic       rdy;
    logic       can;
    logic [2:0] occ;
    logic       vld;
  } vec_t;

  vec_t tbl [11];
  int   guard;
  int   start;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd3, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'd4, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b1};

    bus.in_issue = 1'b0;
    bus.out_rdy  = 1'b0;
    do_reset();

    // Reset state, then a single item.
    @(negedge clk);
    chk("rst_occ", 32'(bus.occ), 32'd0);
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_out_dat", 32'(bus.out_dat), 32'd0);
    chk("rst_can_issue", 32'(bus.can_issue), 32'd1);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    nd = 32'h123;
    l_dat = nd[W-1:0];
    bus.in_issue = 1'b1;
    bus.out_rdy  = 1'b1;
    tick();
    bus.in_issue = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("single_pipe_vld_t3", 32'(bus.pipe_vld), 32'd1);
    chk("single_no_bypass_t3", 32'(bus.out_vld), 32'd0);
    tick();
    @(negedge clk);
    chk("single_out_vld_t4", 32'(bus.out_vld), 32'd1);
    chk("single_out_dat_t4", 32'(bus.out_dat), 32'h123);
    chk("single_occ_t4", 32'(bus.occ), 32'd1);
    tick();
    @(negedge clk);
    chk("single_occ_t5", 32'(bus.occ), 32'd0);
    chk("single_out_dat_t5", 32'(bus.out_dat), 32'd0);

    // Credit limit, then a pop from full. The vector table starts in the
    // first cycle after reset.
    do_reset();
    nd = 1;
    l_dat = nd[W-1:0];
    for (int i = 0; i < 11; i++) begin
      bus.in_issue = tbl[i].ii;
      bus.out_rdy  = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_can_issue", i), 32'(bus.can_issue), 32'(tbl[i].can));
      chk($sformatf("tbl%0d_occ", i), 32'(bus.occ), 32'(tbl[i].occ));
      chk($sformatf("tbl%0d_out_vld", i), 32'(bus.out_vld), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_ovf", i), 32'(bus.ovf), 32'd0);
      tick();
    end

    // Stream data 0x005..0x00A behind 0x001..0x004, wrapping the pointers.
    bus.in_issue = 1'b1;
    bus.out_rdy  = 1'b1;
    guard = 0;
    while (nd <= 10 && guard < 60) begin
      tick();
      guard++;
    end
    chk("stream_launched", 32'(nd), 32'd11);
    bus.in_issue = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    chk("stream_drained_occ", 32'(bus.occ), 32'd0);
    chk("stream_sb_empty", 32'(q.size()), 32'd0);

    // Forced overflow while full. A push at full with a pop must succeed.
    bus.out_rdy  = 1'b0;
    bus.in_issue = 1'b1;
    repeat (5) tick();
    bus.in_issue = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("ovf_pre_occ", 32'(bus.occ), 32'd4);
    chk("ovf_pre_can_issue", 32'(bus.can_issue), 32'd0);
    inj_vld = 1'b1;
    inj_dat = 12'hFFF;
    tick();
    inj_vld = 1'b0;
    @(negedge clk);
    chk("ovf_set", 32'(bus.ovf), 32'd1);
    chk("ovf_occ", 32'(bus.occ), 32'd4);
    chk("ovf_head", 32'(bus.out_dat), 32'(q[0]));
    repeat (3) tick();
    @(negedge clk);
    chk("ovf_sticky", 32'(bus.ovf), 32'd1);
    inj_vld = 1'b1;
    inj_dat = 12'hABC;
    bus.out_rdy = 1'b1;
    q.push_back(12'hABC);
    tick();
    inj_vld = 1'b0;
    bus.out_rdy = 1'b0;
    @(negedge clk);
    chk("full_pushpop_occ", 32'(bus.occ), 32'd4);
    chk("full_pushpop_head", 32'(bus.out_dat), 32'(q[0]));
    bus.out_rdy = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("ovf_drain_occ", 32'(bus.occ), 32'd0);
    chk("ovf_drain_sb", 32'(q.size()), 32'd0);

    // Reset with three stored items and one item in flight.
    bus.out_rdy  = 1'b0;
    bus.in_issue = 1'b1;
    repeat (3) tick();
    bus.in_issue = 1'b0;
    repeat (2) tick();
    bus.in_issue = 1'b1;
    tick();
    bus.in_issue = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_pre_occ", 32'(bus.occ), 32'd3);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_occ", 32'(bus.occ), 32'd0);
    chk("midrst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("midrst_out_dat", 32'(bus.out_dat), 32'd0);
    chk("midrst_can_issue", 32'(bus.can_issue), 32'd1);
    chk("midrst_ovf", 32'(bus.ovf), 32'd0);
    bus.out_rdy = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("midrst_late_sb", 32'(q.size()), 32'd0);
    chk("midrst_late_occ", 32'(bus.occ), 32'd0);

    // Random stall traffic.
    do_reset();
    start = nd;
    rnd = 1'b1;
    guard = 0;
    while ((nd - start) < 1000 && guard < 20000) begin
      bus.in_issue = 1'($urandom_range(0, 1));
      bus.out_rdy  = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    chk("rnd_launched", 32'(nd - start), 32'd1000);
    bus.in_issue = 1'b0;
    bus.out_rdy  = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    @(negedge clk);
    rnd = 1'b0;
    chk("rnd_sb_empty", 32'(q.size()), 32'd0);
    chk("rnd_final_occ", 32'(bus.occ), 32'd0);
    chk("rnd_final_ovf", 32'(bus.ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
